// File: rtl/bp_me_pkg.sv
// Shared coherence-NoC wormhole definitions: header layout and FSM state encodings used by the
// concentrator and by the header encoders.
package bp_me_pkg;

   localparam int unsigned bp_cord_width_gp  = 8;
   localparam int unsigned bp_len_width_gp   = 4;
   localparam int unsigned bp_cid_width_gp   = 3;

   // Header fields sit LSB-first: cord, then len, then cid; everything above is payload.
   localparam int unsigned bp_cord_offset_gp = 0;
   localparam int unsigned bp_len_offset_gp  = bp_cord_offset_gp + bp_cord_width_gp;
   localparam int unsigned bp_cid_offset_gp  = bp_len_offset_gp + bp_len_width_gp;
   localparam int unsigned bp_hdr_width_gp   = bp_cid_offset_gp + bp_cid_width_gp;

   typedef struct packed {
      logic [bp_cid_width_gp-1:0]  cid;
      logic [bp_len_width_gp-1:0]  len;
      logic [bp_cord_width_gp-1:0] cord;
   } bp_me_hdr_s;

   typedef enum logic {
      FwdIdle,
      FwdLocked
   } bp_fwd_state_e;

   typedef enum logic [1:0] {
      RetIdle,
      RetRoute,
      RetDrop
   } bp_ret_state_e;

endpackage

// File: rtl/bp_me_rr_arb.sv
// Round-robin grant: searches upward from ptr_i with wrap and returns the first requester.
module bp_me_rr_arb #(
   parameter int unsigned num_in_p = 4
) (
   input  logic [num_in_p-1:0]         req_i,
   input  logic [$clog2(num_in_p)-1:0] ptr_i,
   output logic                        grant_v_o,
   output logic [$clog2(num_in_p)-1:0] grant_id_o
);

   localparam int unsigned id_width_lp = $clog2(num_in_p);

   // Walk from farthest to nearest so the nearest requester above ptr_i is written last.
   always_comb begin
      int unsigned idx;
      idx        = 0;
      grant_v_o  = 1'b0;
      grant_id_o = '0;
      for (int i = int'(num_in_p) - 1; i >= 0; i--) begin
         idx = 32'(ptr_i) + 32'(i);
         if (idx >= num_in_p) begin
            idx = idx - num_in_p;
         end
         if (req_i[idx]) begin
            grant_v_o  = 1'b1;
            grant_id_o = id_width_lp'(idx);
         end
      end
   end

endmodule

// File: rtl/bp_me_wormhole_concentrator_rr.sv
// Concentrates num_in_p wormhole endpoints onto one NoC link with packet-level round-robin, and
// steers returning packets back to the endpoint named by the header cid.
module bp_me_wormhole_concentrator_rr
   import bp_me_pkg::*;
#(
   parameter int unsigned flit_width_p = 64,
   parameter int unsigned cord_width_p = 8,
   parameter int unsigned len_width_p  = 4,
   parameter int unsigned cid_width_p  = 3,
   parameter int unsigned num_in_p     = 4
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_in_p-1:0]              in_v_i,
   input  logic [num_in_p*flit_width_p-1:0] in_data_i,
   output logic [num_in_p-1:0]              in_ready_and_o,
   output logic                             out_v_o,
   output logic [flit_width_p-1:0]          out_data_o,
   input  logic                             out_ready_and_i,
   input  logic                             ret_v_i,
   input  logic [flit_width_p-1:0]          ret_data_i,
   output logic                             ret_ready_and_o,
   output logic [num_in_p-1:0]              ret_v_o,
   output logic [flit_width_p-1:0]          ret_data_o,
   input  logic [num_in_p-1:0]              ret_ready_and_i,
   output logic                             err_bad_cid_o
);

   localparam int unsigned id_width_lp = $clog2(num_in_p);
   localparam int unsigned len_lsb_lp  = cord_width_p;
   localparam int unsigned cid_lsb_lp  = cord_width_p + len_width_p;

   function automatic logic [id_width_lp-1:0] next_id(input logic [id_width_lp-1:0] id);
      return (32'(id) == num_in_p - 32'd1) ? '0 : id + id_width_lp'(1);
   endfunction

   // ---------------------------------------------------------------- forward path
   bp_fwd_state_e            fwd_state_q, fwd_state_d;
   logic [id_width_lp-1:0]   rr_q, rr_d, lock_id_q, lock_id_d;
   logic [len_width_p-1:0]   fwd_cnt_q, fwd_cnt_d;
   logic                     arb_v, sel_v, fwd_ready, fwd_xfer;
   logic [id_width_lp-1:0]   arb_id, sel_id;
   logic [flit_width_p-1:0]  in_flit [num_in_p];
   logic [flit_width_p-1:0]  sel_data;
   logic [len_width_p-1:0]   sel_len;

   logic [flit_width_p-1:0]  buf_q [2];
   logic [1:0]               buf_cnt_q, buf_cnt_d;
   logic                     wr_ptr_q, rd_ptr_q, buf_full, buf_enq, buf_deq;

   for (genvar g = 0; g < num_in_p; g++) begin : g_in_slice
      assign in_flit[g] = in_data_i[g*flit_width_p +: flit_width_p];
   end

   bp_me_rr_arb #(
      .num_in_p(num_in_p)
   ) u_arb (
      .req_i     (in_v_i),
      .ptr_i     (rr_q),
      .grant_v_o (arb_v),
      .grant_id_o(arb_id)
   );

   always_comb begin
      sel_v  = arb_v;
      sel_id = arb_id;
      if (fwd_state_q == FwdLocked) begin
         sel_v  = 1'b1;
         sel_id = lock_id_q;
      end
   end

   assign sel_data  = in_flit[sel_id];
   assign sel_len   = sel_data[len_lsb_lp +: len_width_p];
   assign buf_full  = (buf_cnt_q == 2'd2);
   assign fwd_ready = sel_v & ~buf_full & reset_n_i;
   assign fwd_xfer  = fwd_ready & in_v_i[sel_id];
   assign buf_enq   = fwd_xfer;
   assign buf_deq   = out_v_o & out_ready_and_i;

   always_comb begin
      in_ready_and_o         = '0;
      in_ready_and_o[sel_id] = fwd_ready;
   end

   always_comb begin
      fwd_state_d = fwd_state_q;
      rr_d        = rr_q;
      lock_id_d   = lock_id_q;
      fwd_cnt_d   = fwd_cnt_q;
      unique case (fwd_state_q)
         FwdIdle: begin
            if (fwd_xfer) begin
               if (sel_len != '0) begin
                  fwd_cnt_d   = sel_len;
                  lock_id_d   = sel_id;
                  fwd_state_d = FwdLocked;
               end else begin
                  rr_d = next_id(sel_id);
               end
            end
         end
         FwdLocked: begin
            if (fwd_xfer) begin
               fwd_cnt_d = fwd_cnt_q - len_width_p'(1);
               if (fwd_cnt_q == len_width_p'(1)) begin
                  fwd_state_d = FwdIdle;
                  rr_d        = next_id(lock_id_q);
               end
            end
         end
         default: fwd_state_d = FwdIdle;
      endcase
   end

   always_comb begin
      case ({buf_enq, buf_deq})
         2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
         2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
         default: buf_cnt_d = buf_cnt_q;
      endcase
   end

   assign out_v_o    = (buf_cnt_q != 2'd0);
   assign out_data_o = buf_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fwd_state_q <= FwdIdle;
         rr_q        <= '0;
         lock_id_q   <= '0;
         fwd_cnt_q   <= '0;
         buf_q[0]    <= '0;
         buf_q[1]    <= '0;
         buf_cnt_q   <= 2'd0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
      end else begin
         fwd_state_q <= fwd_state_d;
         rr_q        <= rr_d;
         lock_id_q   <= lock_id_d;
         fwd_cnt_q   <= fwd_cnt_d;
         buf_cnt_q   <= buf_cnt_d;
         if (buf_enq) begin
            buf_q[wr_ptr_q] <= sel_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (buf_deq) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   // ---------------------------------------------------------------- return path
   bp_ret_state_e            ret_state_q, ret_state_d;
   logic [id_width_lp-1:0]   ret_cid_q, ret_cid_d;
   logic [len_width_p-1:0]   ret_cnt_q, ret_cnt_d;
   logic                     err_q, err_d;
   logic [cid_width_p-1:0]   ret_hdr_cid;
   logic [id_width_lp-1:0]   ret_hdr_id;
   logic [len_width_p-1:0]   ret_hdr_len;
   logic                     ret_cid_ok, ret_xfer;

   assign ret_hdr_cid   = ret_data_i[cid_lsb_lp +: cid_width_p];
   assign ret_hdr_id    = ret_hdr_cid[id_width_lp-1:0];
   assign ret_hdr_len   = ret_data_i[len_lsb_lp +: len_width_p];
   assign ret_cid_ok    = (32'(ret_hdr_cid) < num_in_p);
   assign ret_data_o    = ret_data_i;
   assign ret_xfer      = ret_v_i & ret_ready_and_o;
   assign err_bad_cid_o = err_q;

   // Bad-cid packets are sunk at full rate so they cannot block the return link.
   always_comb begin
      ret_v_o         = '0;
      ret_ready_and_o = 1'b0;
      unique case (ret_state_q)
         RetIdle: begin
            if (ret_cid_ok) begin
               ret_v_o[ret_hdr_id] = ret_v_i;
               ret_ready_and_o     = ret_ready_and_i[ret_hdr_id];
            end else begin
               ret_ready_and_o = 1'b1;
            end
         end
         RetRoute: begin
            ret_v_o[ret_cid_q] = ret_v_i;
            ret_ready_and_o    = ret_ready_and_i[ret_cid_q];
         end
         RetDrop: ret_ready_and_o = 1'b1;
         default: ret_ready_and_o = 1'b0;
      endcase
      if (!reset_n_i) begin
         ret_v_o         = '0;
         ret_ready_and_o = 1'b0;
      end
   end

   always_comb begin
      ret_state_d = ret_state_q;
      ret_cid_d   = ret_cid_q;
      ret_cnt_d   = ret_cnt_q;
      err_d       = err_q;
      unique case (ret_state_q)
         RetIdle: begin
            if (ret_xfer) begin
               if (!ret_cid_ok) begin
                  err_d = 1'b1;
               end
               if (ret_hdr_len != '0) begin
                  ret_cnt_d   = ret_hdr_len;
                  ret_cid_d   = ret_hdr_id;
                  ret_state_d = ret_cid_ok ? RetRoute : RetDrop;
               end
            end
         end
         RetRoute, RetDrop: begin
            if (ret_xfer) begin
               ret_cnt_d = ret_cnt_q - len_width_p'(1);
               if (ret_cnt_q == len_width_p'(1)) begin
                  ret_state_d = RetIdle;
               end
            end
         end
         default: ret_state_d = RetIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ret_state_q <= RetIdle;
         ret_cid_q   <= '0;
         ret_cnt_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         ret_state_q <= ret_state_d;
         ret_cid_q   <= ret_cid_d;
         ret_cnt_q   <= ret_cnt_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_bp_me_wormhole_concentrator_rr.sv
// Scoreboard bench: packet-level round-robin model predicts the forward order, cid routing
// predicts the return order; monitors pop and compare whenever a flit leaves the DUT.
module tb_bp_me_wormhole_concentrator_rr;
   import bp_me_pkg::*;

   logic         clk_i = 1'b0;
   logic         reset_n_i = 1'b1;
   logic [3:0]   in_v_i = '0;
   logic [255:0] in_data_i = '0;
   logic [3:0]   in_ready_and_o;
   logic         out_v_o;
   logic [63:0]  out_data_o;
   logic         out_ready_and_i = 1'b0;
   logic         ret_v_i = 1'b0;
   logic [63:0]  ret_data_i = '0;
   logic         ret_ready_and_o;
   logic [3:0]   ret_v_o;
   logic [63:0]  ret_data_o;
   logic [3:0]   ret_ready_and_i = '0;
   logic         err_bad_cid_o;

   bp_me_wormhole_concentrator_rr u_dut (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .in_v_i         (in_v_i),
      .in_data_i      (in_data_i),
      .in_ready_and_o (in_ready_and_o),
      .out_v_o        (out_v_o),
      .out_data_o     (out_data_o),
      .out_ready_and_i(out_ready_and_i),
      .ret_v_i        (ret_v_i),
      .ret_data_i     (ret_data_i),
      .ret_ready_and_o(ret_ready_and_o),
      .ret_v_o        (ret_v_o),
      .ret_data_o     (ret_data_o),
      .ret_ready_and_i(ret_ready_and_i),
      .err_bad_cid_o  (err_bad_cid_o)
   );

   always #5 clk_i = ~clk_i;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] ep_q [4][$];
   logic [63:0] model_q [4][$];
   int          fwd_len_q [4][$];
   logic [63:0] exp_fwd [$];
   logic [63:0] ret_q [$];
   int          exp_ret_ep [$];
   logic [63:0] exp_ret_data [$];
   int          ptr_m = 0;
   bit          err_exp = 0;
   int          ret_total = 0;
   int          ret_consumed = 0;
   int          fires [4] = '{0, 0, 0, 0};
   int          oready_mode = 0;
   bit          mon_en = 1;
   logic [3:0]  fire = '0;
   logic        ret_fire = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk_flit(input int len, input int cid);
      logic [63:0] f;
      bp_me_hdr_s  h;
      f      = {$urandom, $urandom};
      h.cord = 8'($urandom);
      h.len  = 4'(len);
      h.cid  = 3'(cid);
      f[bp_hdr_width_gp-1:0] = h;
      return f;
   endfunction

   task automatic push_pkt(input int ep, input int len);
      logic [63:0] f;
      f = mk_flit(len, $urandom_range(0, 7));
      ep_q[ep].push_back(f);
      model_q[ep].push_back(f);
      for (int b = 0; b < len; b++) begin
         f = {$urandom, $urandom};
         ep_q[ep].push_back(f);
         model_q[ep].push_back(f);
      end
      fwd_len_q[ep].push_back(len + 1);
   endtask

   task automatic push_ret(input int cid, input int len);
      logic [63:0] f;
      for (int b = 0; b <= len; b++) begin
         f = (b == 0) ? mk_flit(len, cid) : {$urandom, $urandom};
         ret_q.push_back(f);
         if (cid < 4) begin
            exp_ret_ep.push_back(cid);
            exp_ret_data.push_back(f);
         end
      end
      if (cid >= 4) err_exp = 1;
      ret_total += len + 1;
   endtask

   // Whole packets granted in round-robin order over endpoints with packets still waiting.
   task automatic run_model();
      bit found;
      int e, n;
      found = 1;
      while (found) begin
         found = 0;
         for (int i = 0; i < 4; i++) begin
            e = (ptr_m + i) % 4;
            if (!found && fwd_len_q[e].size() > 0) begin
               found = 1;
               n = fwd_len_q[e].pop_front();
               repeat (n) exp_fwd.push_back(model_q[e].pop_front());
               ptr_m = (e + 1) % 4;
            end
         end
      end
   endtask

   function automatic bit busy();
      int pend;
      pend = exp_fwd.size() + ret_q.size() + exp_ret_ep.size();
      for (int e = 0; e < 4; e++) pend += ep_q[e].size();
      return pend != 0;
   endfunction

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (n < 3000 && busy()) begin
         @(posedge clk_i);
         n++;
      end
      checks++;
      if (busy()) begin
         errors++;
         $display("FAIL %s drain: got fwd_pending=%0d ret_pending=%0d required 0/0", name,
                  exp_fwd.size(), exp_ret_ep.size());
      end
      repeat (3) @(posedge clk_i);
   endtask

   // Forward driver: endpoints hold valid while they have flits; ready pattern set by mode.
   initial begin
      forever begin
         @(negedge clk_i);
         for (int e = 0; e < 4; e++) begin
            if (fire[e] && ep_q[e].size() > 0) begin
               void'(ep_q[e].pop_front());
               fires[e]++;
            end
         end
         for (int e = 0; e < 4; e++) begin
            in_v_i[e] = (ep_q[e].size() > 0);
            in_data_i[e*64 +: 64] = (ep_q[e].size() > 0) ? ep_q[e][0] : 64'd0;
         end
         out_ready_and_i = (oready_mode == 1) ? 1'b0 :
                           (oready_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
         #4;
         fire = in_v_i & in_ready_and_o;
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         if (ret_fire && ret_q.size() > 0) void'(ret_q.pop_front());
         ret_v_i         = (ret_q.size() > 0) && ($urandom_range(0, 4) != 0);
         ret_data_i      = (ret_q.size() > 0) ? ret_q[0] : {$urandom, $urandom};
         ret_ready_and_i = 4'($urandom);
         #4;
         ret_fire = ret_v_i & ret_ready_and_o;
         if (ret_fire) ret_consumed++;
      end
   end

   initial begin
      logic [63:0] ed;
      forever begin
         @(negedge clk_i);
         #4;
         if (reset_n_i && mon_en) begin
            if (out_v_o && out_ready_and_i) begin
               checks++;
               if (exp_fwd.size() == 0) begin
                  errors++;
                  $display("FAIL fwd_extra: got flit %0h required none", out_data_o);
               end else begin
                  ed = exp_fwd.pop_front();
                  if (out_data_o !== ed) begin
                     errors++;
                     $display("FAIL fwd_data: got %0h required %0h", out_data_o, ed);
                  end
               end
            end
            checks++;
            if ($countones(in_ready_and_o) > 1) begin
               errors++;
               $display("FAIL in_ready_onehot: got %b required at most one bit", in_ready_and_o);
            end
         end
      end
   end

   initial begin
      int          ee;
      logic [63:0] ed;
      forever begin
         @(negedge clk_i);
         #4;
         if (reset_n_i && mon_en) begin
            checks++;
            if ($countones(ret_v_o) > 1) begin
               errors++;
               $display("FAIL ret_v_onehot: got %b required at most one bit", ret_v_o);
            end
            for (int e = 0; e < 4; e++) begin
               if (ret_v_o[e] && ret_ready_and_i[e]) begin
                  checks++;
                  if (exp_ret_ep.size() == 0) begin
                     errors++;
                     $display("FAIL ret_extra: got ep %0d flit %0h required none", e, ret_data_o);
                  end else begin
                     ee = exp_ret_ep.pop_front();
                     ed = exp_ret_data.pop_front();
                     if (ee != e || ret_data_o !== ed) begin
                        errors++;
                        $display("FAIL ret_data: got ep %0d %0h required ep %0d %0h", e,
                                 ret_data_o, ee, ed);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] f0, f2;
      int          base, n;
      #1 reset_n_i = 1'b0;
      @(negedge clk_i);
      #3;
      check("rst_out_v", 64'(out_v_o), 64'd0);
      check("rst_in_ready", 64'(in_ready_and_o), 64'd0);
      check("rst_ret_v", 64'(ret_v_o), 64'd0);
      check("rst_ret_ready", 64'(ret_ready_and_o), 64'd0);
      check("rst_err", 64'(err_bad_cid_o), 64'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      // Locked packet from endpoint 1 must not be interleaved with endpoint 3.
      oready_mode = 2;
      @(posedge clk_i);
      #1;
      push_pkt(1, 3);
      push_pkt(3, 0);
      run_model();
      wait_drain("lock_1_then_3");

      // Simultaneous single-flit packets: endpoint 0 then 2, one cycle of latency.
      @(posedge clk_i);
      #1;
      push_pkt(0, 0);
      push_pkt(2, 0);
      f0 = ep_q[0][0];
      f2 = ep_q[2][0];
      run_model();
      @(negedge clk_i);
      #3;
      check("lat_out_v_empty", 64'(out_v_o), 64'd0);
      check("grant_ep0", 64'(in_ready_and_o), 64'h1);
      @(negedge clk_i);
      #3;
      check("lat_out_v", 64'(out_v_o), 64'd1);
      check("lat_out_data", out_data_o, f0);
      check("grant_ep2", 64'(in_ready_and_o), 64'h4);
      @(negedge clk_i);
      #3;
      check("second_out_data", out_data_o, f2);
      wait_drain("rr_0_2");

      // Pointer now at 3: endpoint 3 wins over endpoint 0.
      @(posedge clk_i);
      #1;
      push_pkt(0, 0);
      push_pkt(3, 0);
      run_model();
      wait_drain("rr_ptr_3");

      // Backpressure: two flits fill the skid buffer, then ready drops.
      oready_mode = 1;
      @(posedge clk_i);
      #1;
      base = fires[1];
      push_pkt(1, 2);
      run_model();
      repeat (5) @(negedge clk_i);
      #3;
      check("bp_in_ready", 64'(in_ready_and_o), 64'd0);
      check("bp_accepted", 64'(fires[1] - base), 64'd2);
      check("bp_out_v", 64'(out_v_o), 64'd1);
      oready_mode = 0;
      wait_drain("backpressure");

      // Return path: good cid with toggling ready, then a bad cid that is sunk.
      @(posedge clk_i);
      #1;
      push_ret(2, 1);
      push_ret(5, 2);
      wait_drain("ret_directed");
      check("err_sticky", 64'(err_bad_cid_o), 64'd1);
      check("ret_consumed_dir", 64'(ret_consumed), 64'(ret_total));

      // Random concurrent traffic on both paths.
      for (int it = 0; it < 20; it++) begin
         @(posedge clk_i);
         #1;
         for (int e = 0; e < 4; e++) begin
            repeat ($urandom_range(0, 2)) push_pkt(e, $urandom_range(0, 3));
         end
         run_model();
         repeat ($urandom_range(1, 3)) push_ret($urandom_range(0, 5), $urandom_range(0, 3));
         wait_drain("random");
      end
      check("err_final", 64'(err_bad_cid_o), 64'(err_exp));
      check("ret_consumed", 64'(ret_consumed), 64'(ret_total));

      // Reset mid-packet while locked with two body flits outstanding.
      mon_en = 0;
      oready_mode = 2;
      @(posedge clk_i);
      #1;
      base = fires[2];
      push_pkt(2, 3);
      n = 0;
      while (n < 50 && fires[2] - base < 2) begin
         @(negedge clk_i);
         #3;
         n++;
      end
      check("locked_cnt2_reached", 64'(fires[2] - base), 64'd2);
      reset_n_i = 1'b0;
      #1;
      check("midrst_out_v", 64'(out_v_o), 64'd0);
      check("midrst_in_ready", 64'(in_ready_and_o), 64'd0);
      check("midrst_ret_v", 64'(ret_v_o), 64'd0);
      check("midrst_ret_ready", 64'(ret_ready_and_o), 64'd0);
      check("midrst_err", 64'(err_bad_cid_o), 64'd0);
      for (int e = 0; e < 4; e++) begin
         ep_q[e].delete();
         model_q[e].delete();
         fwd_len_q[e].delete();
      end
      exp_fwd.delete();
      ptr_m = 0;
      err_exp = 0;
      @(negedge clk_i);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      mon_en = 1;
      oready_mode = 0;
      @(posedge clk_i);
      #1;
      push_pkt(3, 0);
      push_pkt(1, 0);
      run_model();
      wait_drain("after_reset");
      check("err_after_reset", 64'(err_bad_cid_o), 64'(err_exp));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_me_wormhole_concentrator_rr.md
BP_ME_WORMHOLE_CONCENTRATOR_RR -- requirements
Module: bp_me_wormhole_concentrator_rr

Interface
REQ-001 SHALL have parameter flit_width_p, default 64, coherence-NoC flit width in bits.
REQ-002 SHALL have parameter cord_width_p, default 8, destination-coordinate field width.
REQ-003 SHALL have parameter len_width_p, default 4, field giving the number of body flits after the header.
REQ-004 SHALL have parameter cid_width_p, default 3, concentrator-id field width.
REQ-005 SHALL have parameter num_in_p, default 4, number of local endpoints; legal range 2..2**cid_width_p.
REQ-006 SHALL place header fields LSB-first as cord [cord_width_p-1:0], then len, then cid; all remaining bits are payload.
REQ-007 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-008 reset_n_i  input  1  reset, asynchronous and active-low.
REQ-009 in_v_i  input  num_in_p  per-endpoint flit valid toward the network.
REQ-010 in_data_i  input  num_in_p*flit_width_p  per-endpoint flits; endpoint i occupies slice i.
REQ-011 in_ready_and_o  output  num_in_p  per-endpoint ready; a transfer occurs when v and ready are both high.
REQ-012 out_v_o / out_data_o  output  1 / flit_width_p  concentrated flit toward the network.
REQ-013 out_ready_and_i  input  1  network ready.
REQ-014 ret_v_i / ret_data_i  input  1 / flit_width_p  flits returning from the network.
REQ-015 ret_ready_and_o  output  1  return-path ready.
REQ-016 ret_v_o / ret_data_o  output  num_in_p / flit_width_p  return flits, steered to one endpoint; data is shared by all endpoints.
REQ-017 ret_ready_and_i  input  num_in_p  per-endpoint return ready.
REQ-018 err_bad_cid_o  output  1  sticky flag, set when a return header carries cid >= num_in_p.

Function
REQ-019 Forward FSM SHALL have two states, IDLE and LOCKED; only the selected endpoint sees in_ready_and_o high.
REQ-020 In IDLE, SHALL grant round-robin among asserted in_v_i, starting at priority pointer rr_r and searching upward with wrap.
REQ-021 On a granted header transfer with len != 0, SHALL load len into body counter cnt_r and enter LOCKED on the winner.
REQ-022 On a granted header transfer with len == 0, SHALL stay in IDLE and set rr_r = winner+1 (mod num_in_p).
REQ-023 In LOCKED, SHALL accept only the locked endpoint and decrement cnt_r per accepted flit.
REQ-024 In LOCKED, the flit that makes cnt_r 0 SHALL return the FSM to IDLE and set rr_r = locked+1 (mod num_in_p).
REQ-025 SHALL never interleave flits of different packets on out_*.
REQ-026 Forward path SHALL use a 2-entry skid buffer: latency 1 cycle and sustained 1 flit/cycle.
REQ-027 Forward path SHALL deassert in_ready_and_o only when the buffer is full.
REQ-028 Flits SHALL pass through unmodified.
REQ-029 Return FSM SHALL have states IDLE, ROUTE and DROP; ret_ready_and_o is combinational.
REQ-030 Return IDLE on a header with cid < num_in_p: SHALL assert ret_v_o[cid] only, with ret_ready_and_o = ret_ready_and_i[cid].
REQ-031 Return IDLE: a header with len != 0 SHALL latch cid and the body count and enter ROUTE.
REQ-032 Return IDLE on a header with cid >= num_in_p: SHALL hold ret_ready_and_o = 1 and assert no ret_v_o.
REQ-033 A bad-cid header SHALL set err_bad_cid_o and enter DROP if len != 0.
REQ-034 ROUTE and DROP SHALL decrement per accepted flit and return to IDLE after the last body flit.
REQ-035 Forward and return paths SHALL operate independently; simultaneous traffic on both paths SHALL not stall either.

Reset
REQ-036 While reset_n_i is low, SHALL hold outputs at: out_v_o=0, ret_v_o=0, in_ready_and_o=0, ret_ready_and_o=0, err_bad_cid_o=0.
REQ-037 While reset_n_i is low, both FSMs SHALL be IDLE, rr_r=0, counters=0, and the skid buffer empty.
REQ-038 Reset asserted mid-packet SHALL abandon the packet; the first flit after release SHALL be treated as a header.

Structure
REQ-039 Header field offsets and a packed header typedef (cord, len, cid) SHALL live in bp_me_pkg, shared with the encoders.
REQ-040 The FSM state enums SHALL live in bp_me_pkg.
REQ-041 The round-robin grant (pointer plus wrap search) SHALL be sub-module bp_me_rr_arb with parameter num_in_p.

Verification
REQ-042 Endpoints 0 and 2 each post a 1-flit packet in the same cycle, rr_r=0 -> endpoint 0 appears on out first, then endpoint 2; rr_r ends at 3.
REQ-043 Endpoint 1 sends a header with len=3, and endpoint 3 is valid throughout -> 4 contiguous flits from endpoint 1, then endpoint 3.
REQ-044 out_ready_and_i held low for 5 cycles during a len=2 packet -> no flit lost or duplicated; in_ready_and_o drops after 2 buffered flits.
REQ-045 Return header with cid=2 and len=1, with ret_ready_and_i[2] toggling -> both flits delivered only on ret_v_o[2].
REQ-046 num_in_p=4, return header with cid=5 and len=2 -> 3 flits consumed, no ret_v_o, err_bad_cid_o=1 until reset.
REQ-047 Reset asserted during LOCKED with cnt_r=2 -> outputs go to their reset values immediately; next in flit is arbitrated as a header.
